// File: rtl/ahb_fir_stream_master.sv
// AHB-Lite master feeding the FIR slave from valid/ready streams.
// Writes coefficients/samples, polls status, returns filtered results.
module ahb_fir_stream_master #(
    parameter int POLL_LIMIT = 255,
    parameter int PW         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coeff_valid,
    input  logic [63:0] coeff_data,
    output logic        coeff_ready,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        result_valid,
    output logic [15:0] result_data,
    output logic        result_err,
    input  logic        result_ready,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);

    typedef enum logic [2:0] {
        S_IDLE, S_CWR, S_CSET, S_CPOLL,
        S_SWR, S_SPOLL, S_RRD, S_OUT
    } state_t;

    localparam logic [PW:0] LIMIT = (PW+1)'(POLL_LIMIT);

    state_t        state_q, state_d;
    logic          ph_q, ph_d;
    logic [1:0]    k_q, k_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW:0]   cnt_inc;
    logic [63:0]   coeff_q, coeff_d;
    logic [15:0]   smp_q, smp_d;
    logic          err_q, err_d, err_n;
    logic          rvalid_q, rvalid_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic          hsel_q, hsel_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [3:0]    haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [15:0]   hwdata_q, hwdata_d;

    // Handshake accepts in the IDLE cycle; coefficients win over samples.
    assign coeff_ready  = !rst && (state_q == S_IDLE) && coeff_valid;
    assign sample_ready = !rst && (state_q == S_IDLE) && !coeff_valid
                          && sample_valid;

    assign cnt_inc      = {1'b0, cnt_q} + 1'b1;
    assign hsize        = 1'b1;
    assign result_valid = rvalid_q;
    assign result_data  = rdata_q;
    assign result_err   = rerr_q;
    assign hsel         = hsel_q;
    assign htrans       = htrans_q;
    assign haddr        = haddr_q;
    assign hwrite       = hwrite_q;
    assign hwdata       = hwdata_q;

    // Next-state, datapath and bus decode of the upcoming cycle.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        coeff_d  = coeff_q;
        smp_d    = smp_q;
        err_n    = err_q | (ph_q & hresp);
        err_d    = err_n;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        unique case (state_q)
            S_IDLE: begin
                if (coeff_valid) begin
                    coeff_d = coeff_data;
                    k_d     = 2'd0;
                    ph_d    = 1'b0;
                    state_d = S_CWR;
                end else if (sample_valid) begin
                    smp_d   = sample_data;
                    ph_d    = 1'b0;
                    state_d = S_SWR;
                end
            end
            S_OUT: begin
                if (result_ready) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    unique case (state_q)
                        S_CWR: begin
                            if (k_q == 2'd3) state_d = S_CSET;
                            else k_d = k_q + 2'd1;
                        end
                        S_CSET: begin
                            cnt_d   = '0;
                            state_d = S_CPOLL;
                        end
                        S_CPOLL: begin
                            if (hrdata == 16'h0000) begin
                                state_d = S_IDLE;
                            end else if (cnt_inc >= LIMIT) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                cnt_d = cnt_inc[PW-1:0];
                            end
                        end
                        S_SWR: begin
                            cnt_d   = '0;
                            state_d = S_SPOLL;
                        end
                        S_SPOLL: begin
                            if (!hrdata[0]) begin
                                err_d   = err_n | hrdata[8];
                                state_d = S_RRD;
                            end else if (cnt_inc >= LIMIT) begin
                                rvalid_d = 1'b1;
                                rdata_d  = 16'h0000;
                                rerr_d   = 1'b1;
                                state_d  = S_OUT;
                            end else begin
                                cnt_d = cnt_inc[PW-1:0];
                            end
                        end
                        default: begin
                            rvalid_d = 1'b1;
                            rdata_d  = hrdata;
                            rerr_d   = err_n;
                            state_d  = S_OUT;
                        end
                    endcase
                end
            end
        endcase

        hsel_d   = 1'b0;
        htrans_d = 2'b00;
        haddr_d  = 4'h0;
        hwrite_d = 1'b0;
        hwdata_d = 16'h0000;
        unique case (state_d)
            S_CWR: begin
                haddr_d  = 4'h6 + {1'b0, k_d, 1'b0};
                hwrite_d = 1'b1;
                hwdata_d = coeff_d[{k_d, 4'b0000} +: 16];
            end
            S_CSET: begin
                haddr_d  = 4'hE;
                hwrite_d = 1'b1;
                hwdata_d = 16'h0001;
            end
            S_CPOLL: haddr_d = 4'hE;
            S_SWR: begin
                haddr_d  = 4'h4;
                hwrite_d = 1'b1;
                hwdata_d = smp_d;
            end
            S_SPOLL: haddr_d = 4'h0;
            S_RRD:   haddr_d = 4'h2;
            default: hwdata_d = 16'h0000;
        endcase
        if (state_d == S_IDLE || state_d == S_OUT || ph_d) begin
            haddr_d  = 4'h0;
            hwrite_d = 1'b0;
        end else begin
            hsel_d   = 1'b1;
            htrans_d = 2'b10;
        end
    end

    // All state and registered outputs; reset drops the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ph_q     <= 1'b0;
            k_q      <= 2'd0;
            cnt_q    <= '0;
            coeff_q  <= 64'h0;
            smp_q    <= 16'h0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 16'h0;
            rerr_q   <= 1'b0;
            hsel_q   <= 1'b0;
            htrans_q <= 2'b00;
            haddr_q  <= 4'h0;
            hwrite_q <= 1'b0;
            hwdata_q <= 16'h0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            coeff_q  <= coeff_d;
            smp_q    <= smp_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            hsel_q   <= hsel_d;
            htrans_q <= htrans_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end

endmodule

// File: doc/ahb_fir_stream_master.md
Name: ahb_fir_stream_master

Overview:
- Upstream AHB-Lite master that drives the FIR filter slave over its 16-bit register interface.
- Accepts coefficient sets and samples on valid/ready streams and converts them into slave register writes.
- Polls slave status until the slave is ready, reads back each filtered result, and presents it on an output valid/ready stream.
- Sits between the sample source and the FIR slave; it is the only master on that bus.

Parameters:
- POLL_LIMIT, 255, maximum status reads per poll loop before timeout abort.
- PW, 8, width of the internal poll counter; must satisfy 2^PW > POLL_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coeff_valid  in  1  coefficient set offered.
- coeff_data  in  64  F0=[15:0], F1=[31:16], F2=[47:32], F3=[63:48].
- coeff_ready  out  1  coefficient set accepted this cycle.
- sample_valid  in  1  sample offered.
- sample_data  in  16  sample value.
- sample_ready  out  1  sample accepted this cycle.
- result_valid  out  1  result available.
- result_data  out  16  filter output.
- result_err  out  1  slave error, hresp, or timeout for this result.
- result_ready  in  1  consumer accepts result.
- hsel  out  1  slave select.
- haddr  out  4  byte address.
- hsize  out  1  always 1 (halfword).
- htrans  out  2  IDLE=0 or NONSEQ=2.
- hwrite  out  1  write strobe.
- hwdata  out  16  write data, driven in data phase.
- hrdata  in  16  read data, valid in data phase.
- hresp  in  1  error response, sampled in data phase.

Behaviour:
- Slave register map:
  - 0x0 status: bit0 busy, bit8 err.
  - 0x2 result.
  - 0x4 sample.
  - 0x6/0x8/0xA/0xC F0..F3.
  - 0xE coeff-load flag: write 1 to start a load; reads 0 when the load is done.
- Transfer protocol (non-pipelined):
  - Address phase (1 cycle): hsel=1, htrans=2, haddr/hwrite valid.
  - Data phase (next cycle): htrans=0, hsel=0, hwdata held; hrdata and hresp are registered at the end of this cycle.
  - Every transfer is exactly 2 cycles; there is no hready.
- Reset values: all bus outputs 0 except hsize=1; coeff_ready=0, sample_ready=0, result_valid=0, result_data=0, result_err=0; FSM in IDLE.
- FSM states:
  - IDLE: coeff_valid has priority over sample_valid. On coeff_valid, pulse coeff_ready for 1 cycle, latch data, go to CWR(k=0). Otherwise on sample_valid, pulse sample_ready, latch, go to SWR.
  - CWR: write Fk to 0x6+2k; k=0..3, then go to CSET.
  - CSET: write 0x0001 to 0xE, then go to CPOLL.
  - CPOLL: read 0xE. If 0, go to IDLE. Otherwise repeat.
  - SWR: write sample to 0x4, then go to SPOLL.
  - SPOLL: read 0x0. If bit0=0, latch bit8 into the error flag and go to RRD. Otherwise repeat.
  - RRD: read 0x2, latch result_data, go to OUT.
  - OUT: result_valid=1, data/err held stable until result_ready=1, then go to IDLE the next cycle. No other transfer occurs while in OUT.
- Poll counting:
  - The counter is cleared on entry to CPOLL and SPOLL.
  - A poll whose count reaches POLL_LIMIT reads aborts.
  - SPOLL abort: go to OUT with result_data=0, result_err=1.
  - CPOLL abort: go to IDLE; the error is held and ORed into the next result_err.
- hresp:
  - hresp=1 in any data phase sets a sticky error flag.
  - The current sequence still completes; the flag is reported on the next result_err and cleared when that result is accepted.
- Latency:
  - Sample accepted to result_valid, with zero busy polls: 2 (SWR) + 2 (one poll) + 2 (RRD) + 1 = 7 cycles.
  - Coefficient set accepted to IDLE: 4×2 + 2 + 2n cycles, where n is the number of polls.
- Simultaneous coeff_valid and sample_valid: the coefficient set is served first. The sample waits with sample_ready=0.
- Asynchronous rst mid-transfer: bus returns to IDLE immediately, the in-flight result is discarded, and outputs take their reset values.

Test Plan:
- Coefficient load:
  - Stimulus: coeff_data=0x0004_0003_0002_0001, slave reads 0xE as 1 twice, then 0.
  - Required: writes 0x6=1, 0x8=2, 0xA=3, 0xC=4, 0xE=1; three reads of 0xE; coeff_ready pulse exactly 1 cycle.
- Single sample:
  - Stimulus: sample 0x0100, status=0x0000, result=0x0040.
  - Required: result_valid asserts 7 cycles after sample_ready, with result_data=0x0040 and result_err=0.
- Busy then error:
  - Stimulus: status reads 0x0001 three times, then 0x0100.
  - Required: 4 status reads; result_err=1.
- Backpressure:
  - Stimulus: result_ready held low for 10 cycles.
  - Required: result_valid and result_data stable; no bus activity; sample_ready=0.
- Timeout:
  - Stimulus: POLL_LIMIT=4, status is always busy.
  - Required: exactly 4 status reads, then result_valid with result_data=0 and result_err=1.
- Reset mid-transfer:
  - Stimulus: assert rst during the SWR data phase.
  - Required: the same cycle shows htrans=0, hsel=0, result_valid=0; after release, the next sample is handled normally.
